// File: rtl/digital_gates.sv
// Two-input logic-gate demonstrator tile: A = ui_in[0], B = ui_in[1] produce
// eight gate results, which are registered once onto uo_out.
module digital_gates (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic       a;
   logic       b;
   logic [7:0] gates_nxt;
   logic [7:0] gates_p0;
   logic       unused_inputs;

   // Bit order: AND, OR, XOR, NAND, NOR, XNOR, NOT A, NOT B (LSB first)
   function automatic logic [7:0] gate_eval(input logic op_a, input logic op_b);
      logic [7:0] r;
      r[0] = op_a & op_b;
      r[1] = op_a | op_b;
      r[2] = op_a ^ op_b;
      r[3] = ~(op_a & op_b);
      r[4] = ~(op_a | op_b);
      r[5] = ~(op_a ^ op_b);
      r[6] = ~op_a;
      r[7] = ~op_b;
      return r;
   endfunction

   assign a         = ui_in[0];
   assign b         = ui_in[1];
   assign gates_nxt = gate_eval(a, b);

   // Stage p0: the output register is reset to zero, even though several gates
   // would read 1 for A = B = 0, so the tile is dark while held in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gates_p0 <= 8'h00;
      end else if (ena) begin
         gates_p0 <= gates_nxt;
      end
   end

   assign uo_out  = gates_p0;
   assign uio_out = 8'h00;
   assign uio_oe  = 8'h00;

   assign unused_inputs = ^{ui_in[7:2], uio_in};

endmodule

// File: tb/tb_digital_gates.sv
// Directed self-checking bench for digital_gates using immediate assertions.
module tb_digital_gates;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int checks;
   int errors;

   digital_gates dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic check_consts(input string tag);
      check({tag, "_uio_out"}, uio_out, 8'h00);
      check({tag, "_uio_oe"},  uio_oe,  8'h00);
   endtask

   // Drive at the falling edge, then clock once and sample just after the rise.
   task automatic step(input logic [7:0] ui, input logic [7:0] uio);
      @(negedge clk);
      ui_in  = ui;
      uio_in = uio;
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      ena    = 1'b1;
      ui_in  = 8'hFF;
      uio_in = 8'hA5;

      // Reset holds outputs at zero, with and without clock edges
      #2;
      check("reset_async", uo_out, 8'h00);
      check_consts("reset");
      step(8'h00, 8'h00);
      check("reset_clocked", uo_out, 8'h00);

      // Release reset between edges
      @(negedge clk);
      rst_n = 1'b1;
      step(8'h00, 8'h00);
      check("a0b0", uo_out, 8'hF8);
      check_consts("run");

      // No combinational path: input change is invisible until the next edge
      @(negedge clk);
      ui_in = 8'h02;
      #1;
      check("no_comb_path", uo_out, 8'hF8);
      @(posedge clk);
      #1;
      check("a0b1", uo_out, 8'h4E);

      step(8'h01, 8'h3C);
      check("a1b0", uo_out, 8'h8E);

      step(8'h03, 8'hFF);
      check("a1b1", uo_out, 8'h23);
      step(8'hFF, 8'h00);
      check("a1b1_upper_bits", uo_out, 8'h23);
      step(8'hFC, 8'h5A);
      check("a0b0_upper_bits", uo_out, 8'hF8);
      step(8'hFE, 8'h81);
      check("a0b1_upper_bits", uo_out, 8'h4E);
      check_consts("upper");

      // Enable low holds the last value
      step(8'h03, 8'h00);
      check("pre_hold", uo_out, 8'h23);
      @(negedge clk);
      ena = 1'b0;
      step(8'h00, 8'h00);
      check("hold_1", uo_out, 8'h23);
      step(8'h01, 8'h00);
      check("hold_2", uo_out, 8'h23);
      step(8'h00, 8'h00);
      check("hold_3", uo_out, 8'h23);
      @(negedge clk);
      ena = 1'b1;
      @(posedge clk);
      #1;
      check("hold_release", uo_out, 8'hF8);

      // Reset asserted between edges clears immediately
      step(8'h03, 8'h00);
      check("pre_reset", uo_out, 8'h23);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_reset_async", uo_out, 8'h00);
      check_consts("mid_reset");
      @(posedge clk);
      #1;
      check("mid_reset_ena_ignored", uo_out, 8'h00);

      // Release with enable low: no load until an enabled edge
      @(negedge clk);
      rst_n = 1'b1;
      ena   = 1'b0;
      @(posedge clk);
      #1;
      check("release_disabled", uo_out, 8'h00);
      @(negedge clk);
      ena = 1'b1;
      @(posedge clk);
      #1;
      check("release_enabled", uo_out, 8'h23);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
